// File: rtl/runmin_sweep_ctrl_pkg.sv
// runmin_sweep_ctrl shared types and constants.
// FSM state encoding, default widths, stall counter limits.
package runmin_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    RESULT,
    FINISH
  } runmin_ctrl_state_t;

  localparam int LEAF_W_DEF  = 8;
  localparam int QUERY_W_DEF = 9;

  localparam int STALL_W = 16;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  // Saturating increment for the stall counter.
  function automatic logic [STALL_W-1:0] stall_inc(
    input logic [STALL_W-1:0] v
  );
    return (v == STALL_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/runmin_sweep_ctrl_if.sv
// Candidate, running-min and result handshakes of runmin_sweep_ctrl.
// master = controller side, slave = surrounding pipeline side.
interface runmin_sweep_ctrl_if
  import runmin_ctrl_pkg::*;
#(
  parameter int QUERY_W = QUERY_W_DEF
) ();

  logic               cand_valid;
  logic               cand_ready;
  logic               rm_valid;
  logic               rm_restart;
  logic               rm_query_last;
  logic               result_valid;
  logic               result_ready;
  logic [QUERY_W-1:0] result_query;

  modport master (
    input  cand_valid,
    input  result_ready,
    output cand_ready,
    output rm_valid,
    output rm_restart,
    output rm_query_last,
    output result_valid,
    output result_query
  );

  modport slave (
    output cand_valid,
    output result_ready,
    input  cand_ready,
    input  rm_valid,
    input  rm_restart,
    input  rm_query_last,
    input  result_valid,
    input  result_query
  );

endinterface

// File: rtl/runmin_sweep_ctrl_sweep_counter.sv
// Loadable up-counter with a terminal-count flag.
// tc is high while cnt equals last; the owner stops incrementing there.
module sweep_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // Load has priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == last);

endmodule

// File: rtl/runmin_sweep_ctrl.sv
// Per-query running-minimum sequencer for the KNN search pipeline.
// Optional stall counter enabled by defining RUNMIN_CTRL_PERF_EN.
module runmin_sweep_ctrl
  import runmin_ctrl_pkg::*;
#(
  parameter int LEAF_W  = LEAF_W_DEF,
  parameter int QUERY_W = QUERY_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEAF_W-1:0]  num_leaves,
  input  logic [QUERY_W-1:0] num_queries,
  runmin_sweep_ctrl_if.master bus,
  output logic               busy,
  output logic               done
`ifdef RUNMIN_CTRL_PERF_EN
  ,
  output logic [STALL_W-1:0] stall_cycles
`endif
);

  runmin_ctrl_state_t state_q;

  logic [LEAF_W-1:0]  nl_q;
  logic [QUERY_W-1:0] nq_q;
  logic               cand_ready_q;
  logic               result_valid_q;

  logic [LEAF_W-1:0]  leaf_cnt;
  logic               leaf_tc;
  logic [QUERY_W-1:0] query_cnt;
  logic               query_tc;

  logic start_go;
  logic counts_ok;
  logic accept;
  logic res_hs;

  assign start_go  = (state_q == IDLE) & start;
  assign counts_ok = (|num_leaves) & (|num_queries);
  assign accept    = bus.cand_valid & cand_ready_q;
  assign res_hs    = result_valid_q & bus.result_ready;

  sweep_counter #(
    .W(LEAF_W)
  ) u_leaf (
    .clk     (clk),
    .rst     (rst),
    .load    ((start_go & counts_ok) | (accept & leaf_tc)),
    .load_val('0),
    .inc     (accept & ~leaf_tc),
    .last    (nl_q - 1'b1),
    .cnt     (leaf_cnt),
    .tc      (leaf_tc)
  );

  sweep_counter #(
    .W(QUERY_W)
  ) u_query (
    .clk     (clk),
    .rst     (rst),
    .load    (start_go & counts_ok),
    .load_val('0),
    .inc     (res_hs & ~query_tc),
    .last    (nq_q - 1'b1),
    .cnt     (query_cnt),
    .tc      (query_tc)
  );

  // Sweep sequencing with registered handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      nl_q           <= '0;
      nq_q           <= '0;
      cand_ready_q   <= 1'b0;
      result_valid_q <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (counts_ok) begin
              nl_q         <= num_leaves;
              nq_q         <= num_queries;
              cand_ready_q <= 1'b1;
              state_q      <= SWEEP;
            end else begin
              done    <= 1'b1;
              state_q <= FINISH;
            end
          end
        end
        SWEEP: begin
          if (accept && leaf_tc) begin
            cand_ready_q   <= 1'b0;
            result_valid_q <= 1'b1;
            state_q        <= RESULT;
          end
        end
        RESULT: begin
          if (bus.result_ready) begin
            result_valid_q <= 1'b0;
            if (query_tc) begin
              done    <= 1'b1;
              state_q <= FINISH;
            end else begin
              cand_ready_q <= 1'b1;
              state_q      <= SWEEP;
            end
          end
        end
        FINISH: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.cand_ready    = cand_ready_q;
  assign bus.rm_valid      = accept;
  assign bus.rm_restart    = accept & (leaf_cnt == '0);
  assign bus.rm_query_last = accept & leaf_tc;
  assign bus.result_valid  = result_valid_q;
  assign bus.result_query  = query_cnt;

`ifdef RUNMIN_CTRL_PERF_EN
  logic stall_now;

  assign stall_now = ((state_q == SWEEP) & ~bus.cand_valid) |
                     ((state_q == RESULT) & ~bus.result_ready);

  // Starved or backpressured cycles, saturating; cleared per sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (start_go) begin
      stall_cycles <= '0;
    end else if (stall_now) begin
      stall_cycles <= stall_inc(stall_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_runmin_sweep_ctrl.sv
// Self-checking bench for runmin_sweep_ctrl.
// Behavioural sweep model plus directed and randomized sweeps.
module tb_runmin_sweep_ctrl;

  localparam int LW = 8;
  localparam int QW = 9;

  localparam int P_IDLE = 0;
  localparam int P_SW   = 1;
  localparam int P_RES  = 2;
  localparam int P_FIN  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] num_leaves = '0;
  logic [QW-1:0] num_queries = '0;
  logic          busy;
  logic          done;
`ifdef RUNMIN_CTRL_PERF_EN
  logic [15:0]   stall_cycles;
`endif

  runmin_sweep_ctrl_if #(.QUERY_W(QW)) bus ();

  runmin_sweep_ctrl #(
    .LEAF_W (LW),
    .QUERY_W(QW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_leaves  (num_leaves),
    .num_queries (num_queries),
    .bus         (bus),
    .busy        (busy),
    .done        (done)
`ifdef RUNMIN_CTRL_PERF_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model of the sweep: which batch / query we are on, and stall total.
  int m_phase;
  int m_b;
  int m_q;
  int m_L;
  int m_Q;
  int m_stall;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= P_IDLE;
      m_b     <= 0;
      m_q     <= 0;
      m_L     <= 0;
      m_Q     <= 0;
      m_stall <= 0;
    end else begin
      case (m_phase)
        P_IDLE: if (start) begin
          m_stall <= 0;
          if (num_leaves != 0 && num_queries != 0) begin
            m_L     <= int'(num_leaves);
            m_Q     <= int'(num_queries);
            m_b     <= 0;
            m_q     <= 0;
            m_phase <= P_SW;
          end else begin
            m_phase <= P_FIN;
          end
        end
        P_SW: if (bus.cand_valid) begin
          if (m_b + 1 == m_L) begin
            m_b     <= 0;
            m_phase <= P_RES;
          end else begin
            m_b <= m_b + 1;
          end
        end else begin
          m_stall <= (m_stall >= 65535) ? 65535 : m_stall + 1;
        end
        P_RES: if (bus.result_ready) begin
          if (m_q + 1 == m_Q) begin
            m_phase <= P_FIN;
          end else begin
            m_q     <= m_q + 1;
            m_phase <= P_SW;
          end
        end else begin
          m_stall <= (m_stall >= 65535) ? 65535 : m_stall + 1;
        end
        default: m_phase <= P_IDLE;
      endcase
    end
  end

  // Observation counters (actuals), compared later against literals.
  int n_valid = 0;
  int n_restart = 0;
  int n_last = 0;
  int n_both = 0;
  int n_done = 0;
  int n_busy = 0;
  int res_log[$];

  // Per-cycle compare against the model, sampled mid-cycle.
  initial begin
    logic [6:0] ev;
    logic [6:0] av;
    logic       e_cr;
    logic       e_rv;
    forever begin
      @(negedge clk);
      if (!rst) begin
        e_cr = (m_phase == P_SW);
        e_rv = e_cr && bus.cand_valid;
        ev = {e_cr, e_rv, e_rv && (m_b == 0), e_rv && (m_b == m_L - 1),
              m_phase == P_RES, m_phase != P_IDLE, m_phase == P_FIN};
        av = {bus.cand_ready, bus.rm_valid, bus.rm_restart,
              bus.rm_query_last, bus.result_valid, busy, done};
        total++;
        if (av !== ev ||
            (m_phase == P_RES && int'(bus.result_query) != m_q)) begin
          bad++;
          $display("FAIL cycle t=%0t got=%b q=%0d want=%b q=%0d",
                   $time, av, bus.result_query, ev, m_q);
        end
`ifdef RUNMIN_CTRL_PERF_EN
        total++;
        if (int'(stall_cycles) != m_stall) begin
          bad++;
          $display("FAIL stall t=%0t got=%0d want=%0d",
                   $time, stall_cycles, m_stall);
        end
`endif
        n_valid   += int'(bus.rm_valid);
        n_restart += int'(bus.rm_restart);
        n_last    += int'(bus.rm_query_last);
        n_both    += int'(bus.rm_valid & bus.rm_restart & bus.rm_query_last);
        n_done    += int'(done);
        n_busy    += int'(busy);
        if (bus.result_valid && bus.result_ready)
          res_log.push_back(int'(bus.result_query));
      end
    end
  end

  // Upstream / downstream responders.
  int cv_mode  = 3;
  int rr_mode  = 0;
  int rr_dq    = -1;
  int rr_delay = 0;

  initial begin
    int g;
    int w;
    g = 0;
    w = 0;
    bus.cand_valid   = 1'b0;
    bus.result_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (cv_mode)
        0: bus.cand_valid = 1'b1;
        1: bus.cand_valid = 1'($urandom_range(0, 1));
        2: begin
          if (bus.cand_ready) begin
            bus.cand_valid = (g == 2);
            g = (g == 2) ? 0 : g + 1;
          end else begin
            bus.cand_valid = 1'b0;
          end
        end
        default: bus.cand_valid = 1'b0;
      endcase
      if (bus.result_valid) begin
        if (rr_mode == 1)
          bus.result_ready = 1'($urandom_range(0, 1));
        else if (int'(bus.result_query) == rr_dq)
          bus.result_ready = (w >= rr_delay);
        else
          bus.result_ready = 1'b1;
        w++;
      end else begin
        w = 0;
        bus.result_ready = (rr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic do_start(input int l, input int q);
    num_leaves  = LW'(l);
    num_queries = QW'(q);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    bit seen;
    d0 = n_done;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (n_done != d0) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_timeout got=no_done want=done", name);
    end
    tick();
  endtask

  initial begin
    int bv;
    int br;
    int bl;
    int bb;
    int bd;
    int bq;
    int bz;
    int l;
    int q;

    #12;
    check("rst_cand_ready", int'(bus.cand_ready), 0);
    check("rst_rm_valid", int'(bus.rm_valid), 0);
    check("rst_result_valid", int'(bus.result_valid), 0);
    check("rst_result_query", int'(bus.result_query), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;
    tick();

    // 4 batches, 1 query, valid held high
    cv_mode = 0;
    rr_mode = 0;
    rr_dq = -1;
    bv = n_valid; br = n_restart; bl = n_last; bd = n_done;
    bq = res_log.size();
    do_start(4, 1);
    check("t1_ready_after_start", int'(bus.cand_ready), 1);
    wait_done("t1", 50);
    check("t1_valids", n_valid - bv, 4);
    check("t1_restarts", n_restart - br, 1);
    check("t1_lasts", n_last - bl, 1);
    check("t1_dones", n_done - bd, 1);
    check("t1_results", res_log.size() - bq, 1);
    if (res_log.size() > bq) check("t1_rq0", res_log[bq], 0);

    // 3x3 with result backpressure on query 1
    rr_dq = 1;
    rr_delay = 5;
    bv = n_valid;
    bq = res_log.size();
    do_start(3, 3);
    wait_done("t2", 100);
    check("t2_valids", n_valid - bv, 9);
    check("t2_results", res_log.size() - bq, 3);
    if (res_log.size() >= bq + 3) begin
      check("t2_rq0", res_log[bq], 0);
      check("t2_rq1", res_log[bq + 1], 1);
      check("t2_rq2", res_log[bq + 2], 2);
    end

    // single batch per query
    rr_dq = -1;
    bv = n_valid;
    bb = n_both;
    do_start(1, 2);
    wait_done("t3", 50);
    check("t3_valids", n_valid - bv, 2);
    check("t3_both", n_both - bb, 2);

    // zero-count start
    bv = n_valid; bd = n_done; bz = n_busy;
    do_start(0, 5);
    check("t4_done_next", int'(done), 1);
    check("t4_busy_next", int'(busy), 1);
    tick();
    check("t4_done_gone", int'(done), 0);
    tick();
    check("t4_busy_cycles", n_busy - bz, 1);
    check("t4_dones", n_done - bd, 1);
    check("t4_valids", n_valid - bv, 0);

    // reset in the middle of a sweep
    bd = n_done;
    do_start(4, 1);
    for (int i = 0; i < 20 && !(m_phase == P_SW && m_b == 2); i++) tick();
    check("t5_reached_leaf2", m_b, 2);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_cand_ready", int'(bus.cand_ready), 0);
    check("t5_rst_rm_valid", int'(bus.rm_valid), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_result_q", int'(bus.result_query), 0);
    #3;
    rst = 1'b0;
    tick();
    check("t5_no_done", n_done - bd, 0);
    br = n_restart;
    do_start(2, 1);
    #3;
    check("t5_first_restart", int'(bus.rm_restart), 1);
    wait_done("t5", 50);
    check("t5_restarts", n_restart - br, 1);

    // randomized sweeps with ignored starts while busy
    cv_mode = 1;
    rr_mode = 1;
    for (int k = 0; k < 8; k++) begin
      l = $urandom_range(1, 5);
      q = $urandom_range(1, 4);
      bv = n_valid;
      do_start(l, q);
      for (int i = 0; i < 4; i++) tick();
      if (m_phase == P_SW || m_phase == P_RES) begin
        num_leaves = LW'($urandom_range(1, 9));
        num_queries = QW'($urandom_range(1, 9));
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      wait_done("rand", 600);
      check("rand_valids", n_valid - bv, l * q);
    end

`ifdef RUNMIN_CTRL_PERF_EN
    // gapped candidates plus result backpressure
    cv_mode = 2;
    rr_mode = 0;
    rr_dq = 0;
    rr_delay = 3;
    do_start(3, 1);
    wait_done("perf", 100);
    check("perf_stalls", int'(stall_cycles), 9);
    cv_mode = 0;
    rr_dq = -1;
    do_start(2, 2);
    check("perf_cleared", int'(stall_cycles), 0);
    wait_done("perf2", 100);
    check("perf_no_stall", int'(stall_cycles), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/runmin_sweep_ctrl.md
# runmin_sweep_ctrl

Sequencer for the per-query running-minimum stage of the KNN search pipeline. It walks a programmed number of queries. For each query it accepts a programmed number of candidate distance batches from the upstream L2-distance unit and drives the running-min block's valid, restart and query-last controls. After the last batch of each query it presents the settled minimum as a result handshake toward the writeback stage.

## Interface
Parameters:
- LEAF_W, default 8: width of the per-query batch count.
- QUERY_W, default 9: width of the query count and query index.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: one-cycle pulse. Latches num_leaves and num_queries. Ignored unless in IDLE.
- num_leaves, input, LEAF_W: candidate batches per query.
- num_queries, input, QUERY_W: number of queries in the sweep.
- cand_valid, input, 1: upstream batch available.
- cand_ready, output, 1: controller accepts a batch.
- rm_valid, output, 1: drives the running-min valid input.
- rm_restart, output, 1: drives the running-min restart input.
- rm_query_last, output, 1: drives the running-min query-last input.
- result_valid, output, 1: the running-min outputs hold the final minimum for result_query.
- result_ready, input, 1: downstream accepts the result.
- result_query, output, QUERY_W: index of the query whose result is presented.
- busy, output, 1: high in any state other than IDLE.
- done, output, 1: one-cycle pulse when the sweep completes.
- stall_cycles, output, 16: present only with RUNMIN_CTRL_PERF_EN.

## Operation
States are IDLE, SWEEP, RESULT and FINISH.

- IDLE
  - On start with num_leaves≠0 and num_queries≠0: latch the counts, clear leaf_cnt and query_cnt, go to SWEEP.
  - On start with either count equal to 0: go to FINISH. No rm_valid is issued.
- SWEEP
  - cand_ready=1.
  - rm_valid = cand_valid & cand_ready. This path is combinational.
  - rm_restart = rm_valid & (leaf_cnt==0).
  - rm_query_last = rm_valid & (leaf_cnt==num_leaves−1).
  - Each accepted batch increments leaf_cnt.
  - Accepting the last batch of a query clears leaf_cnt and moves to RESULT.
- RESULT
  - cand_ready=0.
  - result_valid=1 and result_query=query_cnt. Both are held stable until result_ready.
  - On result_valid & result_ready:
    - If query_cnt==num_queries−1, go to FINISH.
    - Otherwise increment query_cnt and go to SWEEP.
- FINISH: assert done for one cycle, then go to IDLE.
- num_leaves==1: every accepted batch carries both rm_restart and rm_query_last.
- Counter arithmetic is unsigned. Compare against the latched count minus 1. Counters never wrap, because the compare fires first.
- Reset mid-operation:
  - All state returns to IDLE immediately and all outputs go to their reset values.
  - The latched counts are cleared.
  - Any partially accumulated minimum is abandoned. The next sweep's rm_restart overwrites it.
- start while busy is ignored. The latched counts are unaffected.

## Timing
- Reset values: cand_ready=0, rm_valid=0, rm_restart=0, rm_query_last=0, result_valid=0, result_query=0, busy=0, done=0, stall_cycles=0.
- SWEEP is entered the cycle after start, so cand_ready rises 1 cycle after start.
- Throughput is one batch per cycle while cand_valid is held high.
- The running-min registers update on the edge that accepts a batch. result_valid therefore rises in the cycle immediately after the last batch is accepted; no extra drain cycle is used.
- RESULT→SWEEP costs one bubble cycle per query.
- done rises 1 cycle after the final result handshake, or 1 cycle after start for a zero-count start.

## Configuration
- RUNMIN_CTRL_PERF_EN defined:
  - stall_cycles counts cycles in SWEEP with cand_valid=0, plus cycles in RESULT with result_ready=0.
  - It saturates at 0xFFFF.
  - It clears on an accepted start.
- RUNMIN_CTRL_PERF_EN undefined: the port and the counter are absent, and the remaining behaviour is identical.

## Structure
- Package runmin_ctrl_pkg holds:
  - the state enum runmin_ctrl_state_t (IDLE, SWEEP, RESULT, FINISH);
  - the default widths LEAF_W_DEF=8 and QUERY_W_DEF=9;
  - the stall counter width and its saturation constant.
- Sub-module sweep_counter: a loadable up-counter with terminal-count flag, instantiated twice (leaf_cnt and query_cnt).
- Everything else is one flat FSM in the top module.

## Test plan
- num_leaves=4, num_queries=1, cand_valid held high:
  - rm_valid is high for 4 consecutive cycles.
  - rm_restart is high on batch 0 only; rm_query_last is high on batch 3 only.
  - result_valid with result_query=0 rises the next cycle; done follows the handshake.
- num_leaves=3, num_queries=3, result_ready delayed 5 cycles on query 1:
  - cand_ready stays 0 during the wait.
  - result_query sequence is 0, 1, 2.
  - Exactly 9 rm_valid pulses.
- num_leaves=1, num_queries=2: every rm_valid carries both rm_restart and rm_query_last.
- start with num_leaves=0: done pulses 1 cycle later, busy is high for 1 cycle, and rm_valid never asserts.
- rst asserted mid-SWEEP (leaf_cnt=2):
  - All outputs return to reset values asynchronously.
  - A subsequent start runs a clean sweep with rm_restart on its first batch.
- With RUNMIN_CTRL_PERF_EN: cand_valid gapped 2 cycles per batch plus 3 cycles of result backpressure gives the matching stall_cycles total. A second start clears it to 0.
